// File: rtl/reaction_timer_multi.sv
// Multi-round reaction-time tester: LFSR random delay, ms-resolution measurement,
// early-press fault, timeout, and session average/best reporting.
module reaction_timer_multi #(
  parameter int          TICK_CYC    = 100_000,
  parameter int          ROUNDS      = 4,
  parameter int          TIMEOUT_MS  = 1000,
  parameter int          DLY_MIN_MS  = 1000,
  parameter int          DLY_STEP_MS = 250,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          RES_W       = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_btn,
  input  logic             stop_btn,
  input  logic             clear_btn,
  output logic             led0,
  output logic [2:0]       state_o,
  output logic [2:0]       round_o,
  output logic [RES_W-1:0] time_ms,
  output logic [RES_W-1:0] avg_ms,
  output logic [RES_W-1:0] best_ms,
  output logic             timeout_o
);

  localparam int DLY_MAX = DLY_MIN_MS + 15 * DLY_STEP_MS;
  localparam int MS_MAX  = (DLY_MAX > TIMEOUT_MS) ? DLY_MAX : TIMEOUT_MS;
  localparam int MS_W    = $clog2(MS_MAX + 1);
  localparam int PRE_W   = $clog2(TICK_CYC);
  localparam int SUM_W   = RES_W + 3;
  localparam int AVG_SH  = $clog2(ROUNDS);

  localparam logic [PRE_W-1:0] TICK_LAST = PRE_W'(TICK_CYC - 1);
  localparam logic [MS_W-1:0]  TO_MS     = MS_W'(TIMEOUT_MS);
  localparam logic [RES_W-1:0] TO_RES    = RES_W'(TIMEOUT_MS);
  localparam logic [2:0]       LAST_RND  = 3'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM     = 3'd1,
    S_WAIT    = 3'd2,
    S_MEASURE = 3'd3,
    S_HOLD    = 3'd4,
    S_SUMMARY = 3'd5,
    S_FAULT   = 3'd6
  } state_t;

  state_t           state, nxt;
  logic [PRE_W-1:0] pre, pre_d;
  logic [MS_W-1:0]  ms, ms_d, ms_inc, dly, dly_d;
  logic [RES_W-1:0] res, res_d, best, best_d;
  logic [SUM_W-1:0] sum, sum_d;
  logic [2:0]       round, round_d;
  logic             to_flag, to_flag_d;
  logic [15:0]      lfsr;
  logic             tick, dly_hit, to_hit;
  logic             led_d, to_o_d;
  logic [RES_W-1:0] time_d, avg_d;

  function automatic logic [MS_W-1:0] delay_of(input logic [3:0] rnd);
    int d;
    d = DLY_MIN_MS + int'(rnd) * DLY_STEP_MS;
    return MS_W'(d);
  endfunction

  function automatic logic [RES_W-1:0] min_res(input logic [RES_W-1:0] a,
                                               input logic [RES_W-1:0] b);
    return (b < a) ? b : a;
  endfunction

  assign tick    = (pre == TICK_LAST);
  assign ms_inc  = ms + 1'b1;
  // Expiry fires on the tick that would bring the counter to its target.
  assign dly_hit = tick && (ms_inc == dly);
  assign to_hit  = tick && (ms_inc == TO_MS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (clear_btn) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start_btn) nxt = S_ARM;
        S_ARM:     nxt = S_WAIT;
        S_WAIT: begin
          if (stop_btn)     nxt = S_FAULT;
          else if (dly_hit) nxt = S_MEASURE;
        end
        S_MEASURE: if (stop_btn || to_hit) nxt = S_HOLD;
        S_HOLD: begin
          if (round == LAST_RND) nxt = S_SUMMARY;
          else if (start_btn)    nxt = S_ARM;
        end
        S_SUMMARY: if (start_btn) nxt = S_ARM;
        S_FAULT:   if (start_btn) nxt = S_ARM;
        default:   nxt = S_IDLE;
      endcase
    end
  end

  // Datapath next values and Moore outputs derived from the next state.
  always_comb begin
    pre_d     = '0;
    ms_d      = '0;
    dly_d     = dly;
    res_d     = res;
    sum_d     = sum;
    best_d    = best;
    round_d   = round;
    to_flag_d = to_flag;
    if (clear_btn) begin
      dly_d     = '0;
      res_d     = '0;
      sum_d     = '0;
      best_d    = '1;
      round_d   = '0;
      to_flag_d = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_SUMMARY: begin
          if (start_btn) begin
            round_d = '0;
            sum_d   = '0;
            best_d  = '1;
          end
        end
        S_ARM: begin
          dly_d     = delay_of(lfsr[3:0]);
          to_flag_d = 1'b0;
        end
        S_WAIT: begin
          if (!stop_btn && !dly_hit) begin
            pre_d = tick ? '0 : pre + 1'b1;
            ms_d  = tick ? ms_inc : ms;
          end
        end
        S_MEASURE: begin
          if (stop_btn || to_hit) begin
            res_d     = stop_btn ? RES_W'(ms) : TO_RES;
            to_flag_d = !stop_btn;
            sum_d     = sum + SUM_W'(res_d);
            best_d    = min_res(best, res_d);
          end else begin
            pre_d = tick ? '0 : pre + 1'b1;
            ms_d  = tick ? ms_inc : ms;
          end
        end
        S_HOLD: begin
          if (round != LAST_RND && start_btn) round_d = round + 3'd1;
        end
        default: ;
      endcase
    end

    led_d  = (nxt == S_MEASURE);
    to_o_d = (nxt == S_HOLD) && to_flag_d;
    time_d = '0;
    avg_d  = '0;
    case (nxt)
      S_MEASURE: time_d = RES_W'(ms_d);
      S_HOLD:    time_d = res_d;
      S_SUMMARY: avg_d  = RES_W'(sum_d >> AVG_SH);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre       <= '0;
      ms        <= '0;
      dly       <= '0;
      res       <= '0;
      sum       <= '0;
      best      <= '1;
      round     <= '0;
      to_flag   <= 1'b0;
      led0      <= 1'b0;
      time_ms   <= '0;
      avg_ms    <= '0;
      timeout_o <= 1'b0;
    end else begin
      pre       <= pre_d;
      ms        <= ms_d;
      dly       <= dly_d;
      res       <= res_d;
      sum       <= sum_d;
      best      <= best_d;
      round     <= round_d;
      to_flag   <= to_flag_d;
      led0      <= led_d;
      time_ms   <= time_d;
      avg_ms    <= avg_d;
      timeout_o <= to_o_d;
    end
  end

  // Free-running Fibonacci LFSR, taps 16,14,13,11; only rst reloads it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr <= LFSR_SEED;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign state_o = state;
  assign round_o = round;
  assign best_ms = best;

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Directed bench for reaction_timer_multi with small timing parameters.
module tb_reaction_timer_multi;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0, stop_btn = 1'b0, clear_btn = 1'b0;
  logic       led0, timeout_o;
  logic [2:0] state_o, round_o;
  logic [9:0] time_ms, avg_ms, best_ms;
  int         checks = 0;
  int         failures = 0;
  logic [15:0] lf;

  reaction_timer_multi #(
    .TICK_CYC(4), .ROUNDS(4), .TIMEOUT_MS(20), .DLY_MIN_MS(2), .DLY_STEP_MS(1),
    .LFSR_SEED(16'hACE1), .RES_W(10)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .stop_btn(stop_btn),
    .clear_btn(clear_btn), .led0(led0), .state_o(state_o), .round_o(round_o),
    .time_ms(time_ms), .avg_ms(avg_ms), .best_ms(best_ms), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) lf <= 16'hACE1;
    else     lf <= lfsr_next(lf);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic s, input logic p, input logic c);
    start_btn = s; stop_btn = p; clear_btn = c;
    @(negedge clk);
    start_btn = 1'b0; stop_btn = 1'b0; clear_btn = 1'b0;
  endtask

  // Delay is taken from the LFSR value present during ARM, one step after now.
  task automatic start_trial(output int dly);
    logic [15:0] n;
    n = lfsr_next(lf);
    dly = 2 + int'(n[3:0]);
    press(1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    int stop_ms;
    int exp_best;
    int exp_round;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int dly;
    bit found;
    logic [15:0] n;

    vecs[0] = '{8, 8, 0};
    vecs[1] = '{10, 8, 1};
    vecs[2] = '{4, 4, 2};
    vecs[3] = '{6, 4, 3};

    step(3);
    chk("rst_state", int'(state_o), 0);
    chk("rst_led", int'(led0), 0);
    chk("rst_round", int'(round_o), 0);
    chk("rst_time", int'(time_ms), 0);
    chk("rst_avg", int'(avg_ms), 0);
    chk("rst_best", int'(best_ms), 1023);
    chk("rst_timeout", int'(timeout_o), 0);
    rst = 1'b0;
    step(2);

    // Single trial with rnd = 3 -> 5 ms delay
    found = 1'b0;
    for (int k = 0; k < 500; k++) begin
      n = lfsr_next(lf);
      if (n[3:0] == 4'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("rnd3_found", int'(found), 1);
    start_trial(dly);
    chk("t1_arm", int'(state_o), 1);
    step(1);
    chk("t1_wait_first", int'(state_o), 2);
    step(19);
    chk("t1_wait_last", int'(state_o), 2);
    chk("t1_wait_led", int'(led0), 0);
    step(1);
    chk("t1_measure", int'(state_o), 3);
    chk("t1_led_on", int'(led0), 1);
    chk("t1_time0", int'(time_ms), 0);
    step(28);
    chk("t1_live7", int'(time_ms), 7);
    press(1'b0, 1'b1, 1'b0);
    chk("t1_hold", int'(state_o), 4);
    chk("t1_time", int'(time_ms), 7);
    chk("t1_led_off", int'(led0), 0);
    chk("t1_timeout", int'(timeout_o), 0);
    chk("t1_best", int'(best_ms), 7);
    press(1'b0, 1'b0, 1'b1);
    chk("t1_clr_state", int'(state_o), 0);
    chk("t1_clr_best", int'(best_ms), 1023);
    chk("t1_clr_time", int'(time_ms), 0);

    // Four-trial session from the vector table
    for (int i = 0; i < 4; i++) begin
      start_trial(dly);
      chk($sformatf("v%0d_arm", i), int'(state_o), 1);
      chk($sformatf("v%0d_round", i), int'(round_o), vecs[i].exp_round);
      step(4 * dly + 1);
      chk($sformatf("v%0d_measure", i), int'(state_o), 3);
      step(4 * vecs[i].stop_ms);
      chk($sformatf("v%0d_live", i), int'(time_ms), vecs[i].stop_ms);
      press(1'b0, 1'b1, 1'b0);
      chk($sformatf("v%0d_hold", i), int'(state_o), 4);
      chk($sformatf("v%0d_time", i), int'(time_ms), vecs[i].stop_ms);
      chk($sformatf("v%0d_best", i), int'(best_ms), vecs[i].exp_best);
      chk($sformatf("v%0d_timeout", i), int'(timeout_o), 0);
    end
    step(1);
    chk("sum_state", int'(state_o), 5);
    chk("sum_avg", int'(avg_ms), 7);
    chk("sum_best", int'(best_ms), 4);
    chk("sum_time", int'(time_ms), 0);
    press(1'b0, 1'b1, 1'b0);
    chk("sum_stop_ignored", int'(state_o), 5);
    chk("sum_avg_held", int'(avg_ms), 7);

    // New session from SUMMARY, then fault and timeout corners
    start_trial(dly);
    chk("s2_arm", int'(state_o), 1);
    chk("s2_best", int'(best_ms), 1023);
    chk("s2_round", int'(round_o), 0);
    chk("s2_avg", int'(avg_ms), 0);
    step(4);
    press(1'b0, 1'b1, 1'b0);
    chk("early_fault", int'(state_o), 6);
    chk("early_round", int'(round_o), 0);
    chk("early_time", int'(time_ms), 0);
    start_trial(dly);
    chk("retry_arm", int'(state_o), 1);
    chk("retry_round", int'(round_o), 0);
    step(4 * dly);
    chk("expiry_still_wait", int'(state_o), 2);
    press(1'b0, 1'b1, 1'b0);
    chk("expiry_fault", int'(state_o), 6);
    chk("expiry_led", int'(led0), 0);
    chk("expiry_best", int'(best_ms), 1023);
    start_trial(dly);
    step(4 * dly + 1);
    step(79);
    chk("to_pre_state", int'(state_o), 3);
    chk("to_pre_time", int'(time_ms), 19);
    step(1);
    chk("to_state", int'(state_o), 4);
    chk("to_time", int'(time_ms), 20);
    chk("to_flag", int'(timeout_o), 1);
    chk("to_best", int'(best_ms), 20);
    chk("to_round", int'(round_o), 0);
    start_trial(dly);
    chk("r1_round", int'(round_o), 1);
    chk("r1_timeout_clr", int'(timeout_o), 0);
    step(4 * dly + 1);
    step(79);
    press(1'b0, 1'b1, 1'b0);
    chk("stop_at_to_state", int'(state_o), 4);
    chk("stop_at_to_flag", int'(timeout_o), 0);
    start_trial(dly);
    step(4 * dly + 1);
    step(5);
    chk("clr_pre_led", int'(led0), 1);
    press(1'b0, 1'b1, 1'b1);
    chk("clr_state", int'(state_o), 0);
    chk("clr_led", int'(led0), 0);
    chk("clr_best", int'(best_ms), 1023);
    chk("clr_round", int'(round_o), 0);
    chk("clr_time", int'(time_ms), 0);

    // Asynchronous reset in the middle of WAIT
    start_trial(dly);
    step(3);
    chk("ar_pre_wait", int'(state_o), 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_state", int'(state_o), 0);
    chk("ar_led", int'(led0), 0);
    chk("ar_round", int'(round_o), 0);
    chk("ar_best", int'(best_ms), 1023);
    chk("ar_time", int'(time_ms), 0);
    #1 rst = 1'b0;
    @(negedge clk);
    start_trial(dly);
    step(4 * dly);
    chk("seed_wait_last", int'(state_o), 2);
    step(1);
    chk("seed_measure", int'(state_o), 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
